full_adder_2s_reg: RTL and testbench

- 16-bit two's-complement adder/subtractor for the RISC datapath ALU.
- CTRL selects the operation: add (A+B) or subtract (A−B).
- Subtraction is formed as A + ~B + 1. B is XORed with CTRL and CTRL is fed in as carry-in.
- Result, carry-out and signed-overflow flag are registered on one clock with asynchronous active-high reset.

---
 rtl/full_adder_2s_reg.sv | 44 ++++
 tb/tb_full_adder_2s_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/full_adder_2s_reg.sv
// Registered 16-bit two's-complement adder/subtractor for the datapath ALU.
// Subtraction is A + ~B + 1: B is inverted by CTRL and CTRL is the carry-in.
module full_adder_2s_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CTRL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ovf_n;

  assign b_eff    = B ^ {WIDTH{CTRL}};
  assign carry[0] = CTRL;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_n = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      S    <= '0;
      COUT <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      S    <= sum;
      COUT <= carry[WIDTH];
      OVF  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_full_adder_2s_reg.sv
// Self-checking bench for full_adder_2s_reg: reset sequences, directed table
// and randomized vectors against an arithmetic reference model.
module tb_full_adder_2s_reg;

  logic        CLK;
  logic        RST;
  logic        CTRL;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] S;
  logic        COUT;
  logic        OVF;

  int nVectors;
  int nMiscompares;

  typedef struct {
    string       name;
    logic        ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t table_v[7];

  full_adder_2s_reg #(.WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .CTRL(CTRL),
    .A   (A),
    .B   (B),
    .S   (S),
    .COUT(COUT),
    .OVF (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference from plain integer arithmetic: unsigned result for S/COUT,
  // signed range check for OVF.
  function automatic void model(input logic ctrl, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] s,
                                output logic cout, output logic ovf);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    logic [31:0] u;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!ctrl) begin
      u    = 32'(ua + ub);
      cout = (ua + ub) > 65535;
      r    = sa + sb;
    end else begin
      u    = 32'(ua - ub);
      cout = ua >= ub;
      r    = sa - sb;
    end
    s   = u[15:0];
    ovf = (r > 32767) || (r < -32768);
  endfunction

  task automatic applyStimulus(input logic ctrl, input logic [15:0] a, input logic [15:0] b);
    CTRL = ctrl;
    A    = a;
    B    = b;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] s,
                             input logic cout, input logic ovf);
    nVectors++;
    if (S !== s || COUT !== cout || OVF !== ovf) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got S=%h COUT=%b OVF=%b, expected S=%h COUT=%b OVF=%b",
               name, S, COUT, OVF, s, cout, ovf);
    end
  endtask

  initial begin
    logic [15:0] es;
    logic        ec;
    logic        eo;

    nVectors     = 0;
    nMiscompares = 0;

    table_v[0] = '{"add_zero",   1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    table_v[1] = '{"add_small",  1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
    table_v[2] = '{"add_wrap",   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    table_v[3] = '{"add_ovf",    1'b0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1};
    table_v[4] = '{"sub_small",  1'b1, 16'h0008, 16'h0003, 16'h0005, 1'b1, 1'b0};
    table_v[5] = '{"sub_borrow", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
    table_v[6] = '{"sub_ovf",    1'b1, 16'h8000, 16'h7FFF, 16'h0001, 1'b1, 1'b1};

    RST = 1'b0;
    applyStimulus(1'b0, 16'h1234, 16'h1111);
    #3 RST = 1'b1;
    #1 checkOutput("reset_initial", 16'h0000, 1'b0, 1'b0);
    #2 RST = 1'b0;

    @(posedge CLK); #1;
    checkOutput("first_load", 16'h2345, 1'b0, 1'b0);

    // Reset between edges with a pending result must clear immediately.
    #2;
    applyStimulus(1'b1, 16'h0F0F, 16'h0101);
    RST = 1'b1;
    #1 checkOutput("reset_async", 16'h0000, 1'b0, 1'b0);
    @(posedge CLK); #1;
    checkOutput("reset_hold", 16'h0000, 1'b0, 1'b0);
    #2 RST = 1'b0;
    #1 checkOutput("reset_release", 16'h0000, 1'b0, 1'b0);
    @(posedge CLK); #1;
    checkOutput("post_reset_load", 16'h0E0E, 1'b1, 1'b0);

    // Directed vectors on consecutive cycles.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(table_v[i].ctrl, table_v[i].a, table_v[i].b);
      @(posedge CLK); #1;
      checkOutput(table_v[i].name, table_v[i].s, table_v[i].cout, table_v[i].ovf);
    end

    // Inputs changed after an edge must not affect the held output.
    applyStimulus(1'b0, 16'h0001, 16'h0001);
    #3 checkOutput("hold_until_edge", 16'h0001, 1'b1, 1'b1);
    @(posedge CLK); #1;
    checkOutput("ctrl_toggle", 16'h0002, 1'b0, 1'b0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 300; i++) begin
      logic        c;
      logic [15:0] ra;
      logic [15:0] rb;
      c  = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 0) ra = 16'h8000;
      if (i % 10 == 1) rb = 16'h7FFF;
      if (i % 10 == 2) rb = ra;
      model(c, ra, rb, es, ec, eo);
      applyStimulus(c, ra, rb);
      @(posedge CLK); #1;
      checkOutput("random", es, ec, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
